index_period_monitor: RTL and testbench
=======================================

Name: index_period_monitor

Overview:
Multi-channel, parametrised INDEX period monitor. Successor to the single-channel floppy/HDD frequency counter.
- Measures INDEX periods on NUM_CH drive slots concurrently and averages 2^AVG_LOG2 periods per channel.
- Reports average, jitter (max−min) and floppy/HDD class for each channel.
- Runs one-shot for detection, or continuously for spindle-speed monitoring in the 300 MHz HDD domain.

Parameters:
NUM_CH, 4, number of independent INDEX channels
CNT_W, 27, period counter and timeout width
AVG_LOG2, 2, log2 of periods averaged per result block
SYNC_STAGES, 3, synchroniser depth per channel (min 2)
DEFAULT_TIMEOUT, 150000000, timeout used when timeout input is 0
CLASS_THRESHOLD, 30000000, average below this gives class 2 (HDD), otherwise class 1 (floppy)
GLITCH_CYCLES, 16, high-time qualifier length (used only with optional feature)

Ports:
clk  in  1  300 MHz clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin measurement, sampled in idle
abort  in  1  stop all channels
continuous  in  1  0=one-shot, 1=continuous; sampled at start
ch_enable  in  NUM_CH  channel enables; sampled at start
timeout  in  CNT_W  per-period timeout in clocks; 0 selects DEFAULT_TIMEOUT
index_in  in  NUM_CH  raw INDEX inputs, asynchronous
busy  out  1  measurement active
done  out  1  one-cycle completion pulse
ch_valid  out  NUM_CH  channel result valid
ch_timeout  out  NUM_CH  channel timed out
ch_update  out  NUM_CH  one-cycle pulse when the channel's result registers are written
ch_period  out  NUM_CH*CNT_W  averaged period; channel i at bits [i*CNT_W +: CNT_W]
ch_jitter  out  NUM_CH*CNT_W  max−min of periods in the block
ch_class  out  NUM_CH*2  0=none, 1=floppy, 2=HDD

Behaviour:
- Reset: all outputs 0; all channel FSMs IDLE; synchronisers cleared.
- Edge strobe: rising edge of the last synchroniser stage. Latency from pin to strobe is SYNC_STAGES+1 cycles.
- Per-channel FSM: IDLE → ARM on start if the channel is enabled.
  - ARM: wait for the first strobe, then go to MEAS.
  - MEAS: count periods; go to RESULT after 2^AVG_LOG2 periods.
  - RESULT: one cycle, then FIN (one-shot) or MEAS (continuous).
- Period counter: cleared on each strobe, increments every cycle, saturates at all-ones. Strobes D cycles apart record exactly D.
- Accumulator is CNT_W+AVG_LOG2 bits, with no overflow. Average = acc >> AVG_LOG2, truncated. Running min/max give jitter.
- RESULT writes ch_period, ch_jitter and ch_class, sets ch_valid, clears ch_timeout, and pulses ch_update.
- Continuous mode: the strobe that ends a block also starts the next period. No edge is lost and there is no re-arm.
- Timeout: if the counter reaches the active timeout in ARM or MEAS, the partial block is discarded and results are forced to period=0, jitter=0, class=0. ch_timeout=1, ch_valid=0, ch_update pulses.
  - One-shot: channel goes to FIN.
  - Continuous: channel returns to ARM.
- busy: set the cycle after an accepted start.
  - One-shot: clears when all enabled channels reach FIN; done pulses in that same cycle.
  - Continuous: stays set until abort.
- start while busy is ignored. start with ch_enable=0 gives: busy stays 0, done pulses one cycle later.
- abort, including when coincident with start: abort wins.
  - All channels go to IDLE next cycle; busy clears and done pulses once.
  - Completed results are retained. Channels without a completed block get ch_valid=0.
  - abort in idle is ignored.
- Async reset mid-measurement clears everything immediately; no done pulse.
- A strobe coincident with the timeout cycle: the strobe wins.

Optional Feature:
Macro INDEX_GLITCH_FILTER_EN.
- Defined: a synchronised high is accepted as an edge only after GLITCH_CYCLES consecutive high cycles. Strobe latency becomes SYNC_STAGES+GLITCH_CYCLES+1, and shorter pulses are ignored. Periods are unaffected because the offset is constant.
- Undefined: no filter; GLITCH_CYCLES is unused.

Test Plan:
Bench parameters: CNT_W=16, AVG_LOG2=2, CLASS_THRESHOLD=3000, timeout=20000.
- One-shot, ch0 edges every 1000 cycles, ch1 every 5000 → ch0 period=1000 class=2 jitter=0; ch1 period=5000 class=1; a single done pulse after ch1's 5th edge.
- ch2 periods 990/1010/1000/1004 → period=1001, jitter=20, class=2.
- ch3 enabled with no edges → ch_timeout[3]=1, class=0, valid=0 after 20000 cycles; done waits for the other channels.
- Continuous mode, ch0 every 2000 cycles → ch_update every 8000 cycles with period=2000. abort → busy=0 next cycle, done pulses once, and period stays 2000.
- start and abort in the same cycle → busy stays 0, no channel leaves IDLE. start while busy → ignored. reset_n low mid-block → all outputs 0 immediately.
- With INDEX_GLITCH_FILTER_EN, GLITCH_CYCLES=16: 10-cycle pulses interleaved with genuine 50-cycle pulses every 1000 cycles → period=1000, glitches ignored.

Source files
------------

// File: rtl/index_period_monitor.sv
// Multi-channel INDEX period monitor: averages 2^AVG_LOG2 periods per channel, reports jitter and class.
// Optional macro INDEX_GLITCH_FILTER_EN qualifies synchronised highs for GLITCH_CYCLES cycles.
module index_period_monitor #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned CNT_W           = 27,
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned DEFAULT_TIMEOUT = 150000000,
  parameter int unsigned CLASS_THRESHOLD = 30000000,
  parameter int unsigned GLITCH_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [CNT_W-1:0]          timeout,
  input  logic [NUM_CH-1:0]         index_in,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_timeout,
  output logic [NUM_CH-1:0]         ch_update,
  output logic [NUM_CH*CNT_W-1:0]   ch_period,
  output logic [NUM_CH*CNT_W-1:0]   ch_jitter,
  output logic [NUM_CH*2-1:0]       ch_class
);

  localparam int unsigned ACC_W     = CNT_W + AVG_LOG2;
  localparam int unsigned NPER_W    = AVG_LOG2 + 1;
  localparam int unsigned BLOCK_LEN = 1 << AVG_LOG2;
  // A default larger than the counter can hold saturates to all-ones.
  localparam logic [CNT_W-1:0] DEF_TMO =
    (64'(DEFAULT_TIMEOUT) >= (64'(1) << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(DEFAULT_TIMEOUT);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_MEAS, ST_RESULT, ST_FIN} state_e;

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      strobe_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], index_in[i]};
    end
  end

`ifdef INDEX_GLITCH_FILTER_EN
  localparam int unsigned HC_W = $clog2(GLITCH_CYCLES + 1);
  logic [HC_W-1:0] hi_cnt_q [NUM_CH];

  // Count consecutive synchronised high cycles; the edge fires on the qualifying cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) hi_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!sync_q[i][SYNC_STAGES-1])                 hi_cnt_q[i] <= '0;
        else if (hi_cnt_q[i] != HC_W'(GLITCH_CYCLES))  hi_cnt_q[i] <= hi_cnt_q[i] + HC_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      strobe_c[i] = sync_q[i][SYNC_STAGES-1] && (hi_cnt_q[i] == HC_W'(GLITCH_CYCLES - 1));
  end
`else
  logic [NUM_CH-1:0] last_q;
  logic              unused_glitch;
  assign unused_glitch = (GLITCH_CYCLES == 0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= '0;
    else for (int i = 0; i < NUM_CH; i++) last_q[i] <= sync_q[i][SYNC_STAGES-1];
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) strobe_c[i] = sync_q[i][SYNC_STAGES-1] & ~last_q[i];
  end
`endif

  state_e             state_q [NUM_CH], state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q [NUM_CH], cnt_d [NUM_CH];
  logic [ACC_W-1:0]   acc_q [NUM_CH], acc_d [NUM_CH];
  logic [CNT_W-1:0]   min_q [NUM_CH], min_d [NUM_CH];
  logic [CNT_W-1:0]   max_q [NUM_CH], max_d [NUM_CH];
  logic [NPER_W-1:0]  nper_q [NUM_CH], nper_d [NUM_CH];
  logic [CNT_W-1:0]   per_q [NUM_CH], per_d [NUM_CH];
  logic [CNT_W-1:0]   jit_q [NUM_CH], jit_d [NUM_CH];
  logic [1:0]         cls_q [NUM_CH], cls_d [NUM_CH];
  logic [NUM_CH-1:0]  valid_q, valid_d, tflag_q, tflag_d, upd_q, upd_d, comp_q, comp_d, en_q, en_d;
  logic               busy_q, busy_d, done_q, done_d, cont_q, cont_d;
  logic [CNT_W-1:0]   tlim_q, tlim_d;
  logic               start_c, abort_c, all_fin, timed_out;
  logic [CNT_W-1:0]   cnt_inc, avg;

  assign start_c = start & ~abort & ~busy_q;
  assign abort_c = abort & busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        acc_q[i]   <= '0;
        min_q[i]   <= '0;
        max_q[i]   <= '0;
        nper_q[i]  <= '0;
        per_q[i]   <= '0;
        jit_q[i]   <= '0;
        cls_q[i]   <= '0;
      end
      valid_q <= '0; tflag_q <= '0; upd_q <= '0; comp_q <= '0; en_q <= '0;
      busy_q  <= 1'b0; done_q <= 1'b0; cont_q <= 1'b0; tlim_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; acc_q <= acc_d; min_q <= min_d; max_q <= max_d;
      nper_q  <= nper_d;  per_q <= per_d; jit_q <= jit_d; cls_q <= cls_d;
      valid_q <= valid_d; tflag_q <= tflag_d; upd_q <= upd_d; comp_q <= comp_d; en_q <= en_d;
      busy_q  <= busy_d;  done_q <= done_d; cont_q <= cont_d; tlim_q <= tlim_d;
    end
  end

  always_comb begin
    busy_d = busy_q; done_d = 1'b0; cont_d = cont_q; en_d = en_q; tlim_d = tlim_q;
    valid_d = valid_q; tflag_d = tflag_q; upd_d = '0; comp_d = comp_q;
    all_fin = 1'b1; timed_out = 1'b0; cnt_inc = '0; avg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i]; cnt_d[i] = cnt_q[i]; acc_d[i] = acc_q[i];
      min_d[i] = min_q[i]; max_d[i] = max_q[i]; nper_d[i] = nper_q[i];
      per_d[i] = per_q[i]; jit_d[i] = jit_q[i]; cls_d[i] = cls_q[i];
      timed_out = 1'b0;
      cnt_inc = (cnt_q[i] == {CNT_W{1'b1}}) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      avg = acc_q[i][AVG_LOG2 +: CNT_W];
      if (abort_c) begin
        state_d[i] = ST_IDLE;
        valid_d[i] = valid_q[i] & comp_q[i];
      end else begin
        case (state_q[i])
          ST_IDLE, ST_FIN: begin
            if (start_c && ch_enable[i]) begin
              state_d[i] = ST_ARM;
              cnt_d[i]   = CNT_W'(1);
              comp_d[i]  = 1'b0;
            end else if (!busy_q) begin
              state_d[i] = ST_IDLE;
            end
          end
          ST_ARM: begin
            if (strobe_c[i]) begin
              state_d[i] = ST_MEAS;
              cnt_d[i]   = CNT_W'(1);
              nper_d[i]  = '0;
              acc_d[i]   = '0;
            end else if (cnt_q[i] >= tlim_q) begin
              timed_out = 1'b1;
            end else begin
              cnt_d[i] = cnt_inc;
            end
          end
          ST_MEAS: begin
            // The counter value at a strobe is exactly the distance to the previous strobe.
            if (strobe_c[i]) begin
              cnt_d[i]  = CNT_W'(1);
              acc_d[i]  = acc_q[i] + ACC_W'(cnt_q[i]);
              if (nper_q[i] == '0 || cnt_q[i] < min_q[i]) min_d[i] = cnt_q[i];
              if (nper_q[i] == '0 || cnt_q[i] > max_q[i]) max_d[i] = cnt_q[i];
              nper_d[i] = nper_q[i] + NPER_W'(1);
              if (nper_q[i] == NPER_W'(BLOCK_LEN - 1)) state_d[i] = ST_RESULT;
            end else if (cnt_q[i] >= tlim_q) begin
              timed_out = 1'b1;
            end else begin
              cnt_d[i] = cnt_inc;
            end
          end
          ST_RESULT: begin
            per_d[i]   = avg;
            jit_d[i]   = max_q[i] - min_q[i];
            cls_d[i]   = (32'(avg) < 32'(CLASS_THRESHOLD)) ? 2'd2 : 2'd1;
            valid_d[i] = 1'b1;
            tflag_d[i] = 1'b0;
            upd_d[i]   = 1'b1;
            comp_d[i]  = 1'b1;
            cnt_d[i]   = cnt_inc;
            nper_d[i]  = '0;
            acc_d[i]   = '0;
            state_d[i] = cont_q ? ST_MEAS : ST_FIN;
          end
          default: state_d[i] = ST_IDLE;
        endcase
        if (timed_out) begin
          per_d[i]   = '0;
          jit_d[i]   = '0;
          cls_d[i]   = 2'd0;
          tflag_d[i] = 1'b1;
          valid_d[i] = 1'b0;
          upd_d[i]   = 1'b1;
          cnt_d[i]   = CNT_W'(1);
          state_d[i] = cont_q ? ST_ARM : ST_FIN;
        end
      end
      if (en_q[i] && state_d[i] != ST_FIN) all_fin = 1'b0;
    end

    if (abort_c) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (start_c) begin
      if (ch_enable != '0) begin
        busy_d = 1'b1;
        cont_d = continuous;
        en_d   = ch_enable;
        tlim_d = (timeout == '0) ? DEF_TMO : timeout;
      end else begin
        done_d = 1'b1;
      end
    end else if (busy_q && !cont_q && all_fin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ch_valid   = valid_q;
  assign ch_timeout = tflag_q;
  assign ch_update  = upd_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign ch_period[g*CNT_W +: CNT_W] = per_q[g];
    assign ch_jitter[g*CNT_W +: CNT_W] = jit_q[g];
    assign ch_class[g*2 +: 2]          = cls_q[g];
  end

endmodule

// File: tb/tb_index_period_monitor.sv
// Scoreboard bench for index_period_monitor: expected results are queued per channel and
// checked whenever the channel pulses ch_update.
`timescale 1ns/1ps
module tb_index_period_monitor;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMO    = 20000;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     continuous = 1'b0;
  logic [NUM_CH-1:0]        ch_enable = '0;
  logic [CNT_W-1:0]         timeout = 16'(TMO);
  logic [NUM_CH-1:0]        index_in = '0;
  logic                     busy, done;
  logic [NUM_CH-1:0]        ch_valid, ch_timeout, ch_update;
  logic [NUM_CH*CNT_W-1:0]  ch_period, ch_jitter;
  logic [NUM_CH*2-1:0]      ch_class;

  index_period_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .AVG_LOG2(2), .SYNC_STAGES(3),
    .DEFAULT_TIMEOUT(30000), .CLASS_THRESHOLD(3000), .GLITCH_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .continuous(continuous),
    .ch_enable(ch_enable), .timeout(timeout), .index_in(index_in),
    .busy(busy), .done(done), .ch_valid(ch_valid), .ch_timeout(ch_timeout),
    .ch_update(ch_update), .ch_period(ch_period), .ch_jitter(ch_jitter), .ch_class(ch_class)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int jitter;
    int cls;
    bit valid;
    bit tmo;
  } exp_t;

  exp_t    exp_q [NUM_CH][$];
  exp_t    e;
  int      errors = 0;
  int      checks = 0;
  int      done_cnt = 0;
  longint  cyc = 0;
  longint  done_cyc = 0;
  longint  upd_last [NUM_CH];
  longint  upd_prev [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ch_update pops one expected result for that channel.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset_n && ch_update[i]) begin
        upd_prev[i] = upd_last[i];
        upd_last[i] = cyc;
        checks++;
        if (exp_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_update ch%0d: period=%0d valid=%0b timeout=%0b (no update expected)",
                   i, ch_period[i*CNT_W +: CNT_W], ch_valid[i], ch_timeout[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (32'(ch_period[i*CNT_W +: CNT_W]) !== e.period) begin
            errors++;
            $display("FAIL period ch%0d: got %0d expected %0d", i, ch_period[i*CNT_W +: CNT_W], e.period);
          end
          checks++;
          if (32'(ch_jitter[i*CNT_W +: CNT_W]) !== e.jitter) begin
            errors++;
            $display("FAIL jitter ch%0d: got %0d expected %0d", i, ch_jitter[i*CNT_W +: CNT_W], e.jitter);
          end
          checks++;
          if (32'(ch_class[i*2 +: 2]) !== e.cls) begin
            errors++;
            $display("FAIL class ch%0d: got %0d expected %0d", i, ch_class[i*2 +: 2], e.cls);
          end
          checks++;
          if (ch_valid[i] !== e.valid) begin
            errors++;
            $display("FAIL valid ch%0d: got %0b expected %0b", i, ch_valid[i], e.valid);
          end
          checks++;
          if (ch_timeout[i] !== e.tmo) begin
            errors++;
            $display("FAIL timeout_flag ch%0d: got %0b expected %0b", i, ch_timeout[i], e.tmo);
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] en, input logic cont);
    @(negedge clk);
    ch_enable  = en;
    continuous = cont;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // n rising edges, 50-cycle high pulses; gap k uses g0..g3 cyclically; optional 10-cycle mid-gap glitch.
  task automatic pulse_train(input int ch, input int n, input int g0, input int g1,
                             input int g2, input int g3, input bit glitch);
    int gap;
    for (int k = 0; k < n; k++) begin
      index_in[ch] = 1'b1;
      repeat (50) @(negedge clk);
      index_in[ch] = 1'b0;
      if (k < n - 1) begin
        case (k % 4)
          0: gap = g0;
          1: gap = g1;
          2: gap = g2;
          default: gap = g3;
        endcase
        if (glitch) begin
          repeat (gap / 2 - 50) @(negedge clk);
          index_in[ch] = 1'b1;
          repeat (10) @(negedge clk);
          index_in[ch] = 1'b0;
          repeat (gap - gap / 2 - 10) @(negedge clk);
        end else begin
          repeat (gap - 50) @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done_wait: done not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    checks++;
    if ({busy, done, ch_valid, ch_timeout, ch_update} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected all zero", {busy, done, ch_valid, ch_timeout, ch_update});
    end
    checks++;
    if ({ch_period, ch_jitter, ch_class} !== '0) begin
      errors++;
      $display("FAIL reset_results: got %h expected zero", {ch_period, ch_jitter, ch_class});
    end
    reset_n = 1'b1;
    wait_cyc(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_oneshot();
    done_cnt = 0;
    exp_q[0].push_back('{1000, 0, 2, 1'b1, 1'b0});
    exp_q[1].push_back('{5000, 0, 1, 1'b1, 1'b0});
    exp_q[2].push_back('{1001, 20, 2, 1'b1, 1'b0});
    pulse_start(4'b0111, 1'b0);
    fork
      pulse_train(0, 5, 1000, 1000, 1000, 1000, 1'b0);
      pulse_train(1, 5, 5000, 5000, 5000, 5000, 1'b0);
      pulse_train(2, 5, 990, 1010, 1000, 1004, 1'b0);
    join
    wait_done(200, "oneshot");
    wait_cyc(10);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL oneshot_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (done_cyc < upd_last[1]) begin
      errors++;
      $display("FAIL oneshot_done_order: done at %0d before ch1 update at %0d", done_cyc, upd_last[1]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL oneshot_pending ch%0d: %0d results missing, expected 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_timeout();
    done_cnt = 0;
    exp_q[0].push_back('{6000, 0, 1, 1'b1, 1'b0});
    exp_q[3].push_back('{0, 0, 0, 1'b0, 1'b1});
    pulse_start(4'b1001, 1'b0);
    pulse_train(0, 5, 6000, 6000, 6000, 6000, 1'b0);
    wait_done(300, "timeout");
    wait_cyc(10);
    checks++;
    if (ch_timeout[3] !== 1'b1 || ch_valid[3] !== 1'b0 || ch_class[7:6] !== 2'd0) begin
      errors++;
      $display("FAIL timeout_ch3_state: timeout=%b valid=%b class=%0d expected 1/0/0",
               ch_timeout[3], ch_valid[3], ch_class[7:6]);
    end
    checks++;
    if (!(upd_last[3] < upd_last[0] && done_cyc >= upd_last[0])) begin
      errors++;
      $display("FAIL timeout_done_order: ch3 upd %0d ch0 upd %0d done %0d; done must follow ch0",
               upd_last[3], upd_last[0], done_cyc);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_done_count: got %0d expected 1", done_cnt);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL timeout_pending ch%0d: %0d results missing, expected 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_continuous();
    done_cnt = 0;
    exp_q[0].push_back('{2000, 0, 2, 1'b1, 1'b0});
    exp_q[0].push_back('{2000, 0, 2, 1'b1, 1'b0});
    pulse_start(4'b0001, 1'b1);
    pulse_train(0, 9, 2000, 2000, 2000, 2000, 1'b0);
    wait_cyc(300);
    checks++;
    if (upd_last[0] - upd_prev[0] != 8000) begin
      errors++;
      $display("FAIL cont_update_interval: got %0d expected 8000", upd_last[0] - upd_prev[0]);
    end
    checks++;
    if (busy !== 1'b1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL cont_busy_hold: busy=%b done_count=%0d expected 1/0", busy, done_cnt);
    end
    checks++;
    if (exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL cont_pending: %0d results missing, expected 0", exp_q[0].size());
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
    wait_cyc(5);
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (ch_period[15:0] !== 16'd2000 || ch_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_retain: period=%0d valid=%b expected 2000/1", ch_period[15:0], ch_valid[0]);
    end
  endtask

  task automatic test_start_abort();
    @(negedge clk);
    ch_enable = 4'b0001;
    continuous = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_busy: got %b expected 0", busy);
    end
    pulse_train(0, 6, 1000, 1000, 1000, 1000, 1'b0);
    wait_cyc(20);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b expected 0 after edges", busy);
    end
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    exp_q[0].push_back('{1000, 0, 2, 1'b1, 1'b0});
    pulse_start(4'b0001, 1'b0);
    fork
      pulse_train(0, 5, 1000, 1000, 1000, 1000, 1'b0);
      begin
        wait_cyc(2000);
        pulse_start(4'b1110, 1'b1);
      end
    join
    wait_done(200, "busy_start");
    wait_cyc(10);
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: done_count=%0d busy=%b expected 1/0", done_cnt, busy);
    end
    checks++;
    if (exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL busy_start_pending: %0d results missing, expected 0", exp_q[0].size());
    end
  endtask

  task automatic test_reset_mid_block();
    done_cnt = 0;
    exp_q[0].push_back('{1000, 0, 2, 1'b1, 1'b0});
    pulse_start(4'b0001, 1'b1);
    pulse_train(0, 7, 1000, 1000, 1000, 1000, 1'b0);
    wait_cyc(200);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ch_valid, ch_timeout, ch_update} !== '0 || {ch_period, ch_jitter, ch_class} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: flags=%b results=%h expected zero",
               {busy, done, ch_valid, ch_timeout, ch_update}, {ch_period, ch_jitter, ch_class});
    end
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: done_count=%0d busy=%b expected 0/0", done_cnt, busy);
    end
    checks++;
    if (exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL midreset_pending: %0d results missing, expected 0", exp_q[0].size());
    end
  endtask

`ifdef INDEX_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    done_cnt = 0;
    exp_q[0].push_back('{1000, 0, 2, 1'b1, 1'b0});
    pulse_start(4'b0001, 1'b0);
    pulse_train(0, 5, 1000, 1000, 1000, 1000, 1'b1);
    wait_done(200, "glitch");
    wait_cyc(10);
    checks++;
    if (exp_q[0].size() != 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL glitch_result: pending=%0d done_count=%0d expected 0/1", exp_q[0].size(), done_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      upd_last[i] = 0;
      upd_prev[i] = 0;
    end
    test_reset();
    test_oneshot();
    test_timeout();
    test_continuous();
    test_start_abort();
    test_back_to_back();
`ifdef INDEX_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    test_reset_mid_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
